// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        xlen_t     data;
    } wb_req_t;

    // Encoding matters: last_grant resets to SRC_B so A wins the first conflict.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wb_arb_if.sv
// Writeback request bus: two valid/ready sources (A = ALU, B = load) plus flush.
interface rf_wb_arb_if #(
    parameter int XLEN   = rf_pkg::XLEN,
    parameter int REG_AW = rf_pkg::REG_AW
) ();

    logic              flush;
    logic              a_valid;
    logic [REG_AW-1:0] a_rd;
    logic [XLEN-1:0]   a_data;
    logic              a_ready;
    logic              b_valid;
    logic [REG_AW-1:0] b_rd;
    logic [XLEN-1:0]   b_data;
    logic              b_ready;

    modport master (
        output flush,
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready
    );

    modport slave (
        input  flush,
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready
    );

endinterface

// File: rtl/rf_wb_rr2.sv
// Combinational two-way round-robin pick; grant_o[0] = A, grant_o[1] = B.
module rf_wb_rr2
    import rf_pkg::*;
(
    input  logic       valid_a_i,
    input  logic       valid_b_i,
    input  logic       flush_i,
    input  src_e       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        // NOTE: default assignment first so no path leaves grant_o unassigned (no latch).
        grant_o = 2'b00;
        if (!flush_i) begin
            if (valid_a_i && valid_b_i) begin
                grant_o = (last_grant_i == SRC_B) ? 2'b01 : 2'b10;
            end else begin
                grant_o = {valid_b_i, valid_a_i};
            end
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: picks one of two sources per cycle and
// registers the winning write towards the RF; writes to x0 are dropped.
module rf_wb_arb
    import rf_pkg::src_e, rf_pkg::SRC_A, rf_pkg::SRC_B;
#(
    parameter int XLEN   = rf_pkg::XLEN,
    parameter int REG_AW = rf_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_arb_if.slave        wb,
    output logic              rf_write_e,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_write_d,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        grant;
    logic              hs_a;
    logic              hs_b;
    logic              conflict;

    src_e              last_grant_q, last_grant_d;
    logic              wr_e_q, wr_e_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rf_wb_rr2 u_rr2 (
        .valid_a_i    (wb.a_valid),
        .valid_b_i    (wb.b_valid),
        .flush_i      (wb.flush),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Readies are held low while reset is asserted, independent of the clock.
    assign wb.a_ready = grant[0] & rst_n;
    assign wb.b_ready = grant[1] & rst_n;

    assign hs_a     = wb.a_valid & wb.a_ready;
    assign hs_b     = wb.b_valid & wb.b_ready;
    assign conflict = wb.a_valid & wb.b_valid & ~wb.flush;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_e_d       = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;
        if (hs_a) begin
            last_grant_d = SRC_A;
            if (wb.a_rd != '0) begin
                wr_e_d = 1'b1;
                rd_d   = wb.a_rd;
                data_d = wb.a_data;
            end
        end else if (hs_b) begin
            last_grant_d = SRC_B;
            if (wb.b_rd != '0) begin
                wr_e_d = 1'b1;
                rd_d   = wb.b_rd;
                data_d = wb.b_data;
            end
        end
    end

    // Saturating: stops at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (conflict && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_B;
            wr_e_q       <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_e_q       <= wr_e_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rf_write_e   = wr_e_q;
    assign rf_rd        = rd_q;
    assign rf_write_d   = data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter XLEN, default 32, RF data width.
REQ-002 Parameter REG_AW, default 5, RF register address width (32 registers).
REQ-003 Parameter CNT_W, default 16, conflict counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  when 1, no grants this cycle.
REQ-007 a_valid  input  1  source A (ALU writeback) request.
REQ-008 a_rd  input  REG_AW  source A destination register.
REQ-009 a_data  input  XLEN  source A write data.
REQ-010 a_ready  output  1  source A granted this cycle (combinational).
REQ-011 b_valid / b_rd / b_data / b_ready  same as A, for source B (load writeback).
REQ-012 rf_write_e  output  1  registered RF write enable.
REQ-013 rf_rd  output  REG_AW  registered RF destination.
REQ-014 rf_write_d  output  XLEN  registered RF write data.
REQ-015 conflict_cnt  output  CNT_W  count of cycles with both sources valid and flush=0.

Function
REQ-016 Transfer: source X completes a handshake at a rising edge where x_valid=1 and x_ready=1.
REQ-017 Sources shall hold valid, rd and data stable until ready; the block shall not depend on this for correctness of its own state.
REQ-018 At most one grant per cycle; a_ready and b_ready never both 1.
REQ-019 flush=1 -> a_ready=b_ready=0 regardless of valid.
REQ-020 Only one valid (flush=0) -> that source granted.
REQ-021 Both valid (flush=0) -> grant to source not granted last; state bit last_grant (A=0, B=1), reset to B so A wins first conflict.
REQ-022 last_grant updates only on a completed handshake, to the granted source.
REQ-023 Latency: handshake at edge N -> rf_write_e=1 with captured rd/data during cycle N..N+1, so RF commits at edge N+1.
REQ-024 No handshake at edge N -> rf_write_e=0 after edge N; rf_rd/rf_write_d hold last value.
REQ-025 Granted request with rd=0 -> handshake completes, last_grant updates, rf_write_e stays 0 (x0 writes dropped).
REQ-026 Both valid with equal rd -> only granted one written this cycle; other written on a later cycle (program order is the requesters' concern).
REQ-027 conflict_cnt increments by 1 on each edge with a_valid=b_valid=1 and flush=0; saturates at all-ones, no wrap.
REQ-028 Sustained throughput: one RF write per cycle, no bubbles while any source valid and flush=0.

Reset
REQ-029 rst_n=0 asynchronously forces rf_write_e=0, rf_rd=0, rf_write_d=0, conflict_cnt=0, last_grant=B.
REQ-030 a_ready=b_ready=0 while rst_n=0.
REQ-031 Reset mid-operation: pending write in output register discarded (rf_write_e=0 immediately); no grant on first edge after deassert unless valid sampled at that edge.

Structure
REQ-032 Shared package rf_pkg holds XLEN, REG_AW, typedef reg_addr_t, typedef xlen_t, typedef wb_req_t (valid, rd, data), enum src_e {SRC_A, SRC_B}.
REQ-033 One sub-module rf_wb_rr2: combinational 2-way round-robin pick from valids, flush, last_grant; outputs grant vector.
REQ-034 Output register, last_grant and conflict counter in rf_wb_arb top.

Verification
REQ-035 Reset, A only: a_valid=1, a_rd=4, a_data=42 one cycle -> a_ready=1; next cycle rf_write_e=1, rf_rd=4, rf_write_d=42; connected RF reads x4=42.
REQ-036 Conflict alternation: A(rd=2,99) and B(rd=3,7) held valid -> A granted first, B second; rf_write_e high 2 consecutive cycles; conflict_cnt=1 after first edge.
REQ-037 Sustained contention 6 cycles, both valid, new data each grant -> grants A,B,A,B,A,B; conflict_cnt=6; no idle rf_write_e cycle.
REQ-038 x0 drop: B valid rd=0 data=0xDEADBEEF -> b_ready=1, rf_write_e stays 0, next conflict grants A; RF x0 reads 0.
REQ-039 Flush: both valid, flush=1 two cycles -> ready low, rf_write_e=0, conflict_cnt unchanged; flush=0 -> normal round-robin resumes.
REQ-040 Reset mid-write: grant at edge N, rst_n low before edge N+1 -> rf_write_e=0 immediately, RF register unchanged; conflict_cnt=0.
